// File: rtl/hazard_unit.sv
// Hazard detection and forwarding for a 5-stage MIPS pipeline.
// Stall/flush/forward outputs are combinational; a saturating counter tracks stall cycles.
module hazard_unit #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             branchD,
    input  logic [4:0]       RsD,
    input  logic [4:0]       RtD,
    input  logic [4:0]       RsE,
    input  logic [4:0]       RtE,
    input  logic [4:0]       WriteRegE,
    input  logic             RegWriteE,
    input  logic             MemToRegE,
    input  logic [4:0]       WriteRegM,
    input  logic             RegWriteM,
    input  logic             MemToRegM,
    input  logic [4:0]       WriteRegW,
    input  logic             RegWriteW,
    output logic             StallF,
    output logic             StallD,
    output logic             ForwardAD,
    output logic             ForwardBD,
    output logic             FlushE,
    output logic [1:0]       ForwardAE,
    output logic [1:0]       ForwardBE,
    output logic [CNT_W-1:0] StallCount
);

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic             lwstall;
    logic             branchstall;
    logic             stall;
    logic [1:0]       fwd_ae;
    logic [1:0]       fwd_be;
    logic             fwd_ad;
    logic             fwd_bd;
    logic [CNT_W-1:0] stall_count_q;
    logic [CNT_W-1:0] stall_count_d;

    // Memory-stage result is newer than Writeback, so it wins when both match.
    always_comb begin
        fwd_ae = 2'b00;
        if (RsE != 5'd0 && RsE == WriteRegM && RegWriteM)
            fwd_ae = 2'b10;
        else if (RsE != 5'd0 && RsE == WriteRegW && RegWriteW)
            fwd_ae = 2'b01;

        fwd_be = 2'b00;
        if (RtE != 5'd0 && RtE == WriteRegM && RegWriteM)
            fwd_be = 2'b10;
        else if (RtE != 5'd0 && RtE == WriteRegW && RegWriteW)
            fwd_be = 2'b01;

        fwd_ad = (RsD != 5'd0) && (RsD == WriteRegM) && RegWriteM;
        fwd_bd = (RtD != 5'd0) && (RtD == WriteRegM) && RegWriteM;

        // A load result is not available until the end of Memory, so stall even for $0.
        lwstall = MemToRegE && ((RtE == RsD) || (RtE == RtD));
        branchstall = branchD &&
                      ((RegWriteE && (WriteRegE == RsD || WriteRegE == RtD)) ||
                       (MemToRegM && (WriteRegM == RsD || WriteRegM == RtD)));
        stall = lwstall || branchstall;

        if (reset) begin
            fwd_ae = 2'b00;
            fwd_be = 2'b00;
            fwd_ad = 1'b0;
            fwd_bd = 1'b0;
            stall  = 1'b0;
        end
    end

    assign StallF    = stall;
    assign StallD    = stall;
    assign FlushE    = stall;
    assign ForwardAE = fwd_ae;
    assign ForwardBE = fwd_be;
    assign ForwardAD = fwd_ad;
    assign ForwardBD = fwd_bd;

    always_comb begin
        stall_count_d = stall_count_q;
        if (stall && stall_count_q != CNT_MAX)
            stall_count_d = stall_count_q + CNT_ONE;
    end

    always_ff @(posedge clk) begin
        if (reset)
            stall_count_q <= '0;
        else
            stall_count_q <= stall_count_d;
    end

    assign StallCount = stall_count_q;

endmodule

// File: tb/tb_hazard_unit.sv
// Directed bench for hazard_unit: forwarding priority, load-use and branch stalls,
// reset forcing, and the stall counter (including saturation on a narrow instance).
module tb_hazard_unit;

    logic       clk;
    logic       reset;
    logic       branchD;
    logic [4:0] RsD, RtD, RsE, RtE, WriteRegE, WriteRegM, WriteRegW;
    logic       RegWriteE, MemToRegE, RegWriteM, MemToRegM, RegWriteW;

    logic        StallF, StallD, ForwardAD, ForwardBD, FlushE;
    logic [1:0]  ForwardAE, ForwardBE;
    logic [15:0] StallCount;

    logic        s_StallF, s_StallD, s_ForwardAD, s_ForwardBD, s_FlushE;
    logic [1:0]  s_ForwardAE, s_ForwardBE;
    logic [1:0]  s_StallCount;

    int checks = 0;
    int errors = 0;

    hazard_unit #(.CNT_W(16)) dut (
        .clk(clk), .reset(reset), .branchD(branchD),
        .RsD(RsD), .RtD(RtD), .RsE(RsE), .RtE(RtE),
        .WriteRegE(WriteRegE), .RegWriteE(RegWriteE), .MemToRegE(MemToRegE),
        .WriteRegM(WriteRegM), .RegWriteM(RegWriteM), .MemToRegM(MemToRegM),
        .WriteRegW(WriteRegW), .RegWriteW(RegWriteW),
        .StallF(StallF), .StallD(StallD), .ForwardAD(ForwardAD), .ForwardBD(ForwardBD),
        .FlushE(FlushE), .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
        .StallCount(StallCount)
    );

    hazard_unit #(.CNT_W(2)) dut_sat (
        .clk(clk), .reset(reset), .branchD(branchD),
        .RsD(RsD), .RtD(RtD), .RsE(RsE), .RtE(RtE),
        .WriteRegE(WriteRegE), .RegWriteE(RegWriteE), .MemToRegE(MemToRegE),
        .WriteRegM(WriteRegM), .RegWriteM(RegWriteM), .MemToRegM(MemToRegM),
        .WriteRegW(WriteRegW), .RegWriteW(RegWriteW),
        .StallF(s_StallF), .StallD(s_StallD), .ForwardAD(s_ForwardAD), .ForwardBD(s_ForwardBD),
        .FlushE(s_FlushE), .ForwardAE(s_ForwardAE), .ForwardBE(s_ForwardBE),
        .StallCount(s_StallCount)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
            $error("check %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_stall(input string tag, input logic exp);
        check({tag, "_StallF"}, {15'd0, StallF}, {15'd0, exp});
        check({tag, "_StallD"}, {15'd0, StallD}, {15'd0, exp});
        check({tag, "_FlushE"}, {15'd0, FlushE}, {15'd0, exp});
    endtask

    task automatic idle();
        branchD = 0; RsD = 0; RtD = 0; RsE = 0; RtE = 0;
        WriteRegE = 0; RegWriteE = 0; MemToRegE = 0;
        WriteRegM = 0; RegWriteM = 0; MemToRegM = 0;
        WriteRegW = 0; RegWriteW = 0;
    endtask

    initial begin
        // Reset with active hazards on the inputs: everything must be forced inactive.
        reset = 1'b1;
        idle();
        MemToRegE = 1; RtE = 7; RsD = 7; RsE = 7; WriteRegM = 7; RegWriteM = 1;
        @(posedge clk); #1;
        check("rst_count", StallCount, 16'd0);
        check_stall("rst", 1'b0);
        check("rst_ForwardAE", {14'd0, ForwardAE}, 16'd0);
        check("rst_ForwardAD", {15'd0, ForwardAD}, 16'd0);

        // No hazard.
        @(negedge clk); reset = 1'b0; idle();
        RsE = 1; RtE = 2; WriteRegM = 3; WriteRegW = 4; RegWriteM = 1; RegWriteW = 1;
        #1;
        check("nohaz_ForwardAE", {14'd0, ForwardAE}, 16'd0);
        check("nohaz_ForwardBE", {14'd0, ForwardBE}, 16'd0);
        check_stall("nohaz", 1'b0);

        // Memory stage has priority over Writeback.
        @(negedge clk);
        RsE = 5; RtE = 5; WriteRegM = 5; WriteRegW = 5; RegWriteM = 1; RegWriteW = 1;
        #1;
        check("prio_ForwardAE", {14'd0, ForwardAE}, 16'h0002);
        check("prio_ForwardBE", {14'd0, ForwardBE}, 16'h0002);
        @(negedge clk); RegWriteM = 0; #1;
        check("wb_ForwardAE", {14'd0, ForwardAE}, 16'h0001);
        check("wb_ForwardBE", {14'd0, ForwardBE}, 16'h0001);
        @(negedge clk); RsE = 0; RtE = 0; WriteRegM = 0; WriteRegW = 0; RegWriteM = 1; #1;
        check("r0_ForwardAE", {14'd0, ForwardAE}, 16'd0);
        check("r0_ForwardBE", {14'd0, ForwardBE}, 16'd0);

        // Load-use on rs, then on neither, then on rt, then on $0.
        @(negedge clk); idle(); MemToRegE = 1; RtE = 7; RsD = 7; #1;
        check_stall("lw_rs", 1'b1);
        @(negedge clk); RsD = 8; RtD = 6; #1;
        check_stall("lw_none", 1'b0);
        @(negedge clk); RtD = 7; #1;
        check_stall("lw_rt", 1'b1);
        @(negedge clk); idle(); MemToRegE = 1; #1;
        check_stall("lw_r0", 1'b1);

        // Branch hazards.
        @(negedge clk); idle(); branchD = 1; RegWriteE = 1; WriteRegE = 9; RtD = 9; #1;
        check_stall("br_exe", 1'b1);
        @(negedge clk); branchD = 0; #1;
        check_stall("nobr_exe", 1'b0);
        @(negedge clk); idle(); branchD = 1; MemToRegM = 1; RegWriteM = 1; WriteRegM = 9; RsD = 9; #1;
        check_stall("br_mem_load", 1'b1);
        @(negedge clk); MemToRegM = 0; #1;
        check_stall("br_fwd", 1'b0);
        check("br_ForwardAD", {15'd0, ForwardAD}, 16'd1);
        check("br_ForwardBD", {15'd0, ForwardBD}, 16'd0);
        @(negedge clk); RsD = 0; RtD = 9; #1;
        check("br_ForwardAD_b", {15'd0, ForwardAD}, 16'd0);
        check("br_ForwardBD_b", {15'd0, ForwardBD}, 16'd1);

        // Counter: clear, count 3, then 5 (narrow instance saturates at 3).
        @(negedge clk); reset = 1'b1; idle();
        @(posedge clk); #1;
        check("cnt_clear", StallCount, 16'd0);
        check("sat_clear", {14'd0, s_StallCount}, 16'd0);
        @(negedge clk); reset = 1'b0; MemToRegE = 1; RtE = 7; RsD = 7;
        repeat (3) @(posedge clk);
        #1;
        check("cnt_3", StallCount, 16'd3);
        check("sat_3", {14'd0, s_StallCount}, 16'd3);
        repeat (2) @(posedge clk);
        #1;
        check("cnt_5", StallCount, 16'd5);
        check("sat_hold", {14'd0, s_StallCount}, 16'd3);

        // Reset mid-stall: outputs drop at once, counter clears on the edge.
        @(negedge clk); reset = 1'b1; #1;
        check_stall("rst_mid", 1'b0);
        @(posedge clk); #1;
        check("cnt_rst_mid", StallCount, 16'd0);
        check("sat_rst_mid", {14'd0, s_StallCount}, 16'd0);

        // Load-use and branch stall together count once per edge.
        @(negedge clk); reset = 1'b0; idle();
        MemToRegE = 1; RtE = 7; RsD = 7; branchD = 1; RegWriteE = 1; WriteRegE = 7; #1;
        check_stall("both", 1'b1);
        @(posedge clk); #1;
        check("cnt_both", StallCount, 16'd1);
        @(negedge clk); idle();
        @(posedge clk); #1;
        check("cnt_idle", StallCount, 16'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
